// File: rtl/dsp_sequencer.sv
// Instruction sequencer for a small DSP core: fetches one or two program words, waits one
// decode cycle, then runs a one- or multi-cycle EXEC phase that ends in a single ex_en strobe.
module dsp_sequencer #(
  parameter int unsigned PC_W       = 12,
  parameter int unsigned MPY_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt_req,
  input  logic [15:0]     pm_rdata,
  input  logic            pm_ready,
  input  logic [1:0]      pc_sel,
  input  logic            multi_cycle,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  output logic [15:0]     instr,
  output logic            ex_en,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StOpfetch,
    StExec,
    StHalted
  } state_e;

  // The counter is loaded with cycles-remaining-after-this-one, so zero marks the final cycle.
  localparam logic [3:0] CntLoad = 4'(MPY_CYCLES - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     retired_q, retired_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            multi_q, multi_d;
  logic            halt_q, halt_d;
  logic            in_flight;

  logic            pm_req_q, pm_req_d;
  logic [PC_W-1:0] pm_addr_q, pm_addr_d;
  logic            ex_en_q, ex_en_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  assign in_flight = (state_q == StFetch) || (state_q == StDecode) ||
                     (state_q == StOpfetch) || (state_q == StExec);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    multi_d   = multi_q;
    halt_d    = halt_q | (halt_req & in_flight);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          halt_d  = halt_req;
        end
      end
      StHalted: begin
        if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (pm_ready) begin
          instr_d = pm_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        sel_d   = pc_sel;
        multi_d = multi_cycle;
        if (pc_sel == 2'b10) begin
          state_d = StOpfetch;
        end else begin
          state_d = StExec;
          cnt_d   = multi_cycle ? CntLoad : 4'd0;
        end
      end
      StOpfetch: begin
        if (pm_ready) begin
          target_d = pm_rdata[PC_W-1:0];
          state_d  = StExec;
          cnt_d    = multi_q ? CntLoad : 4'd0;
        end
      end
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          retired_d = retired_q + 16'd1;
          case (sel_q)
            2'b10:   pc_d = target_q;
            2'b00:   pc_d = pc_q;
            default: pc_d = pc_q + PC_W'(1);
          endcase
          if (halt_q || halt_req) begin
            state_d = StHalted;
            halt_d  = 1'b0;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    pm_req_d  = (state_d == StFetch) || (state_d == StOpfetch);
    pm_addr_d = (state_d == StOpfetch) ? (pc_d + PC_W'(1)) : pc_d;
    ex_en_d   = (state_d == StExec) && (cnt_d == 4'd0);
    busy_d    = (state_d == StFetch) || (state_d == StDecode) ||
                (state_d == StOpfetch) || (state_d == StExec);
    halted_d  = (state_d == StHalted);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      target_q  <= '0;
      instr_q   <= 16'h0000;
      retired_q <= 16'h0000;
      cnt_q     <= 4'd0;
      sel_q     <= 2'b11;
      multi_q   <= 1'b0;
      halt_q    <= 1'b0;
      pm_req_q  <= 1'b0;
      pm_addr_q <= '0;
      ex_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      multi_q   <= multi_d;
      halt_q    <= halt_d;
      pm_req_q  <= pm_req_d;
      pm_addr_q <= pm_addr_d;
      ex_en_q   <= ex_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign pm_req  = pm_req_q;
  assign pm_addr = pm_addr_q;
  assign instr   = instr_q;
  assign ex_en   = ex_en_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Self-checking bench for dsp_sequencer: program memory and decode LUT are modelled here,
// every ex_en is matched against a scoreboard of expected {PC, instruction} pairs.
module tb_dsp_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic [15:0] pm_rdata;
  logic        pm_ready;
  logic [1:0]  pc_sel;
  logic        multi_cycle;
  logic        pm_req;
  logic [11:0] pm_addr;
  logic [15:0] instr;
  logic        ex_en;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  logic [15:0] mem [4096];
  logic        ready_en;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] word;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [15:0] word;
    logic [15:0] operand;
    int          cycles;
    logic [11:0] next_pc;
  } vec_t;

  vec_t vecs[7];

  dsp_sequencer #(
    .PC_W      (12),
    .MPY_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .pm_rdata   (pm_rdata),
    .pm_ready   (pm_ready),
    .pc_sel     (pc_sel),
    .multi_cycle(multi_cycle),
    .pm_req     (pm_req),
    .pm_addr    (pm_addr),
    .instr      (instr),
    .ex_en      (ex_en),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired)
  );

  // Bench decode LUT: top two bits select next PC, bit 8 flags a multi-cycle op.
  assign pc_sel      = instr[15:14];
  assign multi_cycle = instr[8];
  assign pm_rdata    = mem[pm_addr];
  assign pm_ready    = ready_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (ex_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ex_en", 32'(ex_en), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ex_pc", 32'(pm_addr), 32'(e.pc));
          chk("ex_instr", 32'(instr), 32'(e.word));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    halt_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts cycles until ex_en; call with start/halt_req already set for the coming edge.
  task automatic wait_ex(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      start    = 1'b0;
      halt_req = 1'b0;
      cyc++;
    end while (ex_en !== 1'b1 && cyc < 50);
    chk("ex_en_timeout", 32'(ex_en), 32'd1);
  endtask

  int cyc;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    halt_req = 1'b0;
    ready_en = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    vecs[0] = '{16'h6A05, 16'h0000, 3, 12'h001};
    vecs[1] = '{16'h6D10, 16'h0000, 4, 12'h001};
    vecs[2] = '{16'hB000, 16'h0123, 4, 12'h123};
    vecs[3] = '{16'hB100, 16'h0FFF, 5, 12'hFFF};
    vecs[4] = '{16'h0000, 16'h0000, 3, 12'h000};
    vecs[5] = '{16'hF000, 16'h0000, 3, 12'h001};
    vecs[6] = '{16'h4000, 16'h0000, 3, 12'h001};

    // Reset values, sampled while reset is still held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_pm_req", 32'(pm_req), 32'd0);
    chk("rst_pm_addr", 32'(pm_addr), 32'd0);
    chk("rst_ex_en", 32'(ex_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    reset = 1'b0;

    // One instruction per vector: start with halt_req runs a single instruction then halts.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      mem[0] = vecs[v].word;
      mem[1] = vecs[v].operand;
      sb.push_back('{pc: 12'h000, word: vecs[v].word});
      start    = 1'b1;
      halt_req = 1'b1;
      wait_ex(cyc);
      chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].cycles));
      @(negedge clk);
      chk($sformatf("vec%0d_halted", v), 32'(halted), 32'd1);
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_pm_req", v), 32'(pm_req), 32'd0);
      chk($sformatf("vec%0d_next_pc", v), 32'(pm_addr), 32'(vecs[v].next_pc));
      chk($sformatf("vec%0d_retired", v), 32'(retired), 32'd1);
    end

    // Single-cycle stream.
    do_reset();
    for (int i = 0; i < 6; i++) mem[i] = 16'h6A05;
    for (int i = 0; i < 4; i++) sb.push_back('{pc: 12'(i), word: 16'h6A05});
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ex(cyc);
      chk($sformatf("stream%0d_period", k), 32'(cyc), 32'd3);
    end
    @(negedge clk);
    chk("stream_retired", 32'(retired), 32'd4);
    chk("stream_fetch_addr", 32'(pm_addr), 32'd4);
    chk("stream_fetch_req", 32'(pm_req), 32'd1);
    sb.push_back('{pc: 12'h004, word: 16'h6A05});
    halt_req = 1'b1;
    wait_ex(cyc);
    chk("stream_halt_cycles", 32'(cyc), 32'd2);
    @(negedge clk);
    chk("stream_halted", 32'(halted), 32'd1);
    chk("stream_halt_pc", 32'(pm_addr), 32'd5);

    // Two-word branch from PC=5.
    do_reset();
    mem[0]     = 16'hB000;
    mem[1]     = 16'h0005;
    mem[5]     = 16'hB000;
    mem[6]     = 16'h0123;
    mem[12'h123] = 16'h6A05;
    sb.push_back('{pc: 12'h000, word: 16'hB000});
    sb.push_back('{pc: 12'h005, word: 16'hB000});
    start = 1'b1;
    wait_ex(cyc);
    chk("br_first_cycles", 32'(cyc), 32'd4);
    @(negedge clk);
    chk("br_fetch_addr", 32'(pm_addr), 32'd5);
    chk("br_fetch_req", 32'(pm_req), 32'd1);
    @(negedge clk);
    chk("br_decode_req", 32'(pm_req), 32'd0);
    chk("br_decode_addr", 32'(pm_addr), 32'd5);
    @(negedge clk);
    chk("br_opfetch_req", 32'(pm_req), 32'd1);
    chk("br_opfetch_addr", 32'(pm_addr), 32'd6);
    @(negedge clk);
    chk("br_exec_strobe", 32'(ex_en), 32'd1);
    @(negedge clk);
    chk("br_target_addr", 32'(pm_addr), 32'h123);
    chk("br_retired", 32'(retired), 32'd2);
    sb.push_back('{pc: 12'h123, word: 16'h6A05});
    halt_req = 1'b1;
    wait_ex(cyc);
    @(negedge clk);
    chk("br_halted", 32'(halted), 32'd1);

    // Fetch wait states with a one-cycle halt pulse, then resume from HALTED.
    do_reset();
    mem[0]   = 16'h6A05;
    mem[1]   = 16'h6D10;
    ready_en = 1'b0;
    sb.push_back('{pc: 12'h000, word: 16'h6A05});
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start    = 1'b0;
      halt_req = (i == 2);
      chk($sformatf("wait%0d_pm_req", i), 32'(pm_req), 32'd1);
      chk($sformatf("wait%0d_instr", i), 32'(instr), 32'd0);
    end
    @(negedge clk);
    halt_req = 1'b0;
    chk("wait4_pm_req", 32'(pm_req), 32'd1);
    ready_en = 1'b1;
    @(negedge clk);
    chk("wait_decode_instr", 32'(instr), 32'h6A05);
    chk("wait_decode_req", 32'(pm_req), 32'd0);
    @(negedge clk);
    chk("wait_ex_en", 32'(ex_en), 32'd1);
    @(negedge clk);
    chk("wait_halted", 32'(halted), 32'd1);
    chk("wait_halt_pc", 32'(pm_addr), 32'd1);
    chk("wait_halt_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("wait_stays_halted", 32'(halted), 32'd1);
    sb.push_back('{pc: 12'h001, word: 16'h6D10});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("resume_addr", 32'(pm_addr), 32'd1);
    chk("resume_req", 32'(pm_req), 32'd1);
    chk("resume_busy", 32'(busy), 32'd1);
    halt_req = 1'b1;
    wait_ex(cyc);
    chk("resume_mult_cycles", 32'(cyc), 32'd3);
    @(negedge clk);
    chk("resume_halted", 32'(halted), 32'd1);
    chk("resume_halt_pc", 32'(pm_addr), 32'd2);

    // PC wrap from 12'hFFF.
    do_reset();
    mem[0]       = 16'hB000;
    mem[1]       = 16'h0FFF;
    mem[12'hFFF] = 16'hF000;
    sb.push_back('{pc: 12'h000, word: 16'hB000});
    start    = 1'b1;
    halt_req = 1'b1;
    wait_ex(cyc);
    @(negedge clk);
    chk("wrap_pre_pc", 32'(pm_addr), 32'hFFF);
    sb.push_back('{pc: 12'hFFF, word: 16'hF000});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wrap_fetch_addr", 32'(pm_addr), 32'hFFF);
    halt_req = 1'b1;
    wait_ex(cyc);
    @(negedge clk);
    chk("wrap_pc", 32'(pm_addr), 32'd0);
    chk("wrap_retired", 32'(retired), 32'd2);

    // Reset during the first cycle of a multi-cycle EXEC.
    do_reset();
    mem[0] = 16'h6D10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rexec_busy", 32'(busy), 32'd1);
    chk("rexec_no_strobe", 32'(ex_en), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rexec_ex_en", 32'(ex_en), 32'd0);
    chk("rexec_pm_req", 32'(pm_req), 32'd0);
    chk("rexec_pm_addr", 32'(pm_addr), 32'd0);
    chk("rexec_busy_after", 32'(busy), 32'd0);
    chk("rexec_halted", 32'(halted), 32'd0);
    chk("rexec_retired", 32'(retired), 32'd0);
    chk("rexec_instr", 32'(instr), 32'd0);
    @(negedge clk);
    chk("rexec_stays_idle", 32'(busy), 32'd0);
    chk("rexec_idle_strobe", 32'(ex_en), 32'd0);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
